// File: rtl/ltsm_sbinit_ctrl_pkg.sv
// Shared sideband codes, mux selects and SBINIT states.
// Also used by later link-training phases.
package sb_codex;

    typedef enum logic [2:0] {
        SB_SEL_Z      = 3'd0,
        SB_SEL_DIS    = 3'd1,
        SB_SEL_SBINIT = 3'd2,
        SB_SEL_COMS   = 3'd3
    } SB_mux_sel_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PATTERN,
        ST_TAIL,
        ST_OOR,
        ST_DONE_HS,
        ST_COMPLETE,
        ST_ERROR
    } sbinit_state_t;

    localparam logic [7:0] SBINIT_OOR       = 8'h01;
    localparam logic [7:0] SBINIT_DONE_REQ  = 8'h02;
    localparam logic [7:0] SBINIT_DONE_RESP = 8'h03;

    function automatic SB_mux_sel_t sel_for(sbinit_state_t s);
        SB_mux_sel_t r;
        r = SB_SEL_DIS;
        case (s)
            ST_PATTERN, ST_TAIL:
                r = SB_SEL_SBINIT;
            ST_OOR, ST_DONE_HS, ST_COMPLETE:
                r = SB_SEL_COMS;
            default:
                r = SB_SEL_DIS;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ltsm_sbinit_ctrl_if.sv
// Sideband message TX/RX handshake between SBINIT control
// and the sideband transport.
interface ltsm_sbinit_ctrl_if;
    logic [7:0] tx_msg_o;
    logic       tx_valid_o;
    logic       tx_ack_i;
    logic [7:0] rx_msg_i;
    logic       rx_valid_i;

    modport master (
        output tx_msg_o,
        output tx_valid_o,
        input  tx_ack_i,
        input  rx_msg_i,
        input  rx_valid_i
    );

    modport slave (
        input  tx_msg_o,
        input  tx_valid_o,
        output tx_ack_i,
        output rx_msg_i,
        output rx_valid_i
    );
endinterface

// File: rtl/ltsm_sbinit_ctrl_timer.sv
// Saturating phase timeout counter shared by the
// link-training phase controllers.
module ltsm_timeout_timer #(
    parameter int CYCLES = 800000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);
    localparam int TW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [TW-1:0] LAST = TW'(CYCLES - 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (run && cnt_q != LAST)
            cnt_d = cnt_q + TW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign expired = (cnt_q == LAST);
endmodule

// File: rtl/ltsm_sbinit_ctrl.sv
// SBINIT phase sequencer: clock pattern exchange, then the
// out-of-reset and done message handshakes.
module ltsm_sbinit_ctrl
    import sb_codex::*;
#(
    parameter int TIMEOUT_CYCLES = 800000,
    parameter int DETECT_ITERS   = 2,
    parameter int TAIL_ITERS     = 4
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       enable_i,
    input  logic       start_i,
    input  logic       pattern_iter_done_i,
    input  logic       pattern_detect_i,
    input  logic       pattern_err_i,
    output logic       pattern_tx_en_o,
    output logic [2:0] sb_tx_sel_o,
    output logic       done_o,
    output logic       error_o,
    ltsm_sbinit_ctrl_if.master sb
);
    localparam int DW = $clog2(DETECT_ITERS + 1);
    localparam int AW = $clog2(TAIL_ITERS + 1);
    localparam logic [DW-1:0] DET_N  = DW'(DETECT_ITERS);
    localparam logic [AW-1:0] TAIL_N = AW'(TAIL_ITERS);

    sbinit_state_t state_q, state_d;
    logic [DW-1:0] det_cnt_q, det_cnt_d;
    logic [AW-1:0] tail_cnt_q, tail_cnt_d;
    logic          oor_rx_seen_q, oor_rx_seen_d;
    logic          resp_rx_seen_q, resp_rx_seen_d;
    logic          resp_pending_q, resp_pending_d;
    logic          req_acked_q, req_acked_d;
    logic          pat_en_q, pat_en_d;
    SB_mux_sel_t   sel_q, sel_d;
    logic [7:0]    msg_q, msg_d;
    logic          valid_q, valid_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic active, ack, rx_ok;
    logic rx_oor, rx_req, rx_resp;
    logic expired;

    assign active = (state_q == ST_PATTERN) || (state_q == ST_TAIL) ||
                    (state_q == ST_OOR)     || (state_q == ST_DONE_HS);
    assign ack     = valid_q & sb.tx_ack_i;
    assign rx_ok   = sb.rx_valid_i & active;
    assign rx_oor  = rx_ok && sb.rx_msg_i == SBINIT_OOR &&
                     state_q != ST_DONE_HS;
    assign rx_req  = rx_ok && sb.rx_msg_i == SBINIT_DONE_REQ &&
                     (state_q == ST_OOR || state_q == ST_DONE_HS);
    assign rx_resp = rx_ok && sb.rx_msg_i == SBINIT_DONE_RESP;

    ltsm_timeout_timer #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk_100MHz),
        .rst     (reset),
        .clear   (state_q == ST_IDLE),
        .run     (active),
        .expired (expired)
    );

    always_comb begin
        state_d        = state_q;
        det_cnt_d      = det_cnt_q;
        tail_cnt_d     = tail_cnt_q;
        oor_rx_seen_d  = oor_rx_seen_q;
        resp_rx_seen_d = resp_rx_seen_q;
        resp_pending_d = resp_pending_q;
        req_acked_d    = req_acked_q;
        msg_d          = msg_q;
        valid_d        = valid_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i && enable_i) begin
                    state_d        = ST_PATTERN;
                    det_cnt_d      = '0;
                    tail_cnt_d     = '0;
                    oor_rx_seen_d  = 1'b0;
                    resp_rx_seen_d = 1'b0;
                    resp_pending_d = 1'b0;
                    req_acked_d    = 1'b0;
                end
            end
            ST_PATTERN: begin
                if (pattern_err_i)
                    det_cnt_d = '0;
                else if (pattern_detect_i)
                    det_cnt_d = det_cnt_q + DW'(1);
                if (det_cnt_d == DET_N) begin
                    state_d    = ST_TAIL;
                    tail_cnt_d = '0;
                end
            end
            ST_TAIL: begin
                if (pattern_iter_done_i)
                    tail_cnt_d = tail_cnt_q + AW'(1);
                if (tail_cnt_d == TAIL_N) begin
                    state_d = ST_OOR;
                    valid_d = 1'b1;
                    msg_d   = SBINIT_OOR;
                end
            end
            ST_OOR: begin
                if (ack) begin
                    valid_d = 1'b0;
                    if (oor_rx_seen_q || rx_oor)
                        state_d = ST_DONE_HS;
                end else if (!valid_q) begin
                    valid_d = 1'b1;
                    msg_d   = SBINIT_OOR;
                end
            end
            ST_DONE_HS: begin
                // Own REQ always goes out before any RESP.
                if (ack) begin
                    valid_d = 1'b0;
                    if (msg_q == SBINIT_DONE_REQ)
                        req_acked_d = 1'b1;
                    else if (msg_q == SBINIT_DONE_RESP)
                        resp_pending_d = 1'b0;
                end else if (!valid_q) begin
                    if (!req_acked_q) begin
                        valid_d = 1'b1;
                        msg_d   = SBINIT_DONE_REQ;
                    end else if (resp_pending_q) begin
                        valid_d = 1'b1;
                        msg_d   = SBINIT_DONE_RESP;
                    end else if (resp_rx_seen_q) begin
                        state_d = ST_COMPLETE;
                    end
                end
            end
            ST_COMPLETE, ST_ERROR: begin
                state_d = state_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Partner requests arriving with an ack still count.
        if (rx_oor)
            oor_rx_seen_d = 1'b1;
        if (rx_req)
            resp_pending_d = 1'b1;
        if (rx_resp)
            resp_rx_seen_d = 1'b1;

        if (active && expired)
            state_d = ST_ERROR;
        if (state_q != ST_IDLE && !enable_i)
            state_d = ST_IDLE;

        if (state_d != ST_OOR && state_d != ST_DONE_HS) begin
            valid_d = 1'b0;
            msg_d   = '0;
        end
        pat_en_d = (state_d == ST_PATTERN) || (state_d == ST_TAIL);
        sel_d    = sel_for(state_d);
        done_d   = (state_d == ST_COMPLETE);
        err_d    = (state_d == ST_ERROR);
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            det_cnt_q      <= '0;
            tail_cnt_q     <= '0;
            oor_rx_seen_q  <= 1'b0;
            resp_rx_seen_q <= 1'b0;
            resp_pending_q <= 1'b0;
            req_acked_q    <= 1'b0;
            pat_en_q       <= 1'b0;
            sel_q          <= SB_SEL_DIS;
            msg_q          <= '0;
            valid_q        <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            det_cnt_q      <= det_cnt_d;
            tail_cnt_q     <= tail_cnt_d;
            oor_rx_seen_q  <= oor_rx_seen_d;
            resp_rx_seen_q <= resp_rx_seen_d;
            resp_pending_q <= resp_pending_d;
            req_acked_q    <= req_acked_d;
            pat_en_q       <= pat_en_d;
            sel_q          <= sel_d;
            msg_q          <= msg_d;
            valid_q        <= valid_d;
            done_q         <= done_d;
            err_q          <= err_d;
        end
    end

    assign pattern_tx_en_o = pat_en_q;
    assign sb_tx_sel_o     = sel_q;
    assign done_o          = done_q;
    assign error_o         = err_q;
    assign sb.tx_msg_o     = msg_q;
    assign sb.tx_valid_o   = valid_q;
endmodule

// File: tb/tb_ltsm_sbinit_ctrl.sv
// Directed bench for the SBINIT sequencer with a small
// auto-acking sideband partner.
module tb_ltsm_sbinit_ctrl;
    import sb_codex::*;

    localparam int T = 200;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       start;
    logic       iter;
    logic       det;
    logic       perr;
    logic       pat;
    logic [2:0] sel;
    logic       done;
    logic       err;

    ltsm_sbinit_ctrl_if sb();

    ltsm_sbinit_ctrl #(
        .TIMEOUT_CYCLES (T),
        .DETECT_ITERS   (2),
        .TAIL_ITERS     (4)
    ) dut (
        .clk_100MHz          (clk),
        .reset               (rst),
        .enable_i            (en),
        .start_i             (start),
        .pattern_iter_done_i (iter),
        .pattern_detect_i    (det),
        .pattern_err_i       (perr),
        .pattern_tx_en_o     (pat),
        .sb_tx_sel_o         (sel),
        .done_o              (done),
        .error_o             (err),
        .sb                  (sb)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int hold_bad = 0;
    int ack_delay = 1;
    bit ack_en = 1'b1;
    int cyc = 0;
    int t0;
    int wcnt;
    logic [7:0] held;
    logic [7:0] msg_log[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input bit d, input bit e, input bit i);
        det = d;
        perr = e;
        iter = i;
        tick();
        det = 1'b0;
        perr = 1'b0;
        iter = 1'b0;
    endtask

    task automatic start_run;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic rx(input logic [7:0] code);
        sb.rx_valid_i = 1'b1;
        sb.rx_msg_i = code;
        tick();
        sb.rx_valid_i = 1'b0;
        sb.rx_msg_i = '0;
    endtask

    task automatic abort;
        en = 1'b0;
        tick();
        en = 1'b1;
    endtask

    task automatic wait_done(input string tag, input int maxc);
        int n = 0;
        while (!done && n < maxc) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic chk_log(input string tag);
        logic [7:0] exp [3];
        logic [7:0] got;
        exp[0] = SBINIT_OOR;
        exp[1] = SBINIT_DONE_REQ;
        exp[2] = SBINIT_DONE_RESP;
        chk({tag, "_len"}, msg_log.size(), 32'd3);
        for (int i = 0; i < 3; i++) begin
            got = (i < msg_log.size()) ? msg_log[i] : 8'hee;
            chk($sformatf("%s_msg%0d", tag, i), {24'd0, got},
                {24'd0, exp[i]});
        end
    endtask

    // Partner model: acks each valid after ack_delay waiting cycles
    // and flags any change of the message while it is held.
    initial begin
        sb.tx_ack_i = 1'b0;
        wcnt = 0;
        forever begin
            @(negedge clk);
            if (sb.tx_ack_i) begin
                sb.tx_ack_i = 1'b0;
            end else if (!sb.tx_valid_o) begin
                wcnt = 0;
            end else if (ack_en) begin
                if (wcnt == 0)
                    held = sb.tx_msg_o;
                else if (sb.tx_msg_o !== held)
                    hold_bad++;
                if (wcnt >= ack_delay) begin
                    sb.tx_ack_i = 1'b1;
                    msg_log.push_back(sb.tx_msg_o);
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        en = 1'b0;
        start = 1'b0;
        iter = 1'b0;
        det = 1'b0;
        perr = 1'b0;
        sb.rx_valid_i = 1'b0;
        sb.rx_msg_i = '0;
        #12;
        chk("rst_sel", {29'd0, sel}, 32'd1);
        chk("rst_pat", {31'd0, pat}, 32'd0);
        chk("rst_msg", {24'd0, sb.tx_msg_o}, 32'd0);
        chk("rst_valid", {31'd0, sb.tx_valid_o}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        rst = 1'b0;
        tick();
        en = 1'b1;
        tick();

        // Nominal path
        msg_log.delete();
        t0 = cyc;
        start_run();
        chk("nom_sel_pattern", {29'd0, sel}, 32'd2);
        chk("nom_pat_on", {31'd0, pat}, 32'd1);
        pulse(1, 0, 0);
        pulse(1, 0, 0);
        repeat (3) pulse(0, 0, 1);
        chk("nom_pat_before_4th", {31'd0, pat}, 32'd1);
        pulse(0, 0, 1);
        chk("nom_pat_off", {31'd0, pat}, 32'd0);
        chk("nom_sel_coms", {29'd0, sel}, 32'd3);
        chk("nom_valid_oor", {31'd0, sb.tx_valid_o}, 32'd1);
        chk("nom_msg_oor", {24'd0, sb.tx_msg_o}, 32'h01);
        rx(SBINIT_OOR);
        rx(SBINIT_DONE_REQ);
        rx(SBINIT_DONE_RESP);
        wait_done("nom_done", 100);
        chk("nom_lat", {31'd0, (cyc - t0) < T}, 32'd1);
        chk("nom_err", {31'd0, err}, 32'd0);
        chk("nom_valid_done", {31'd0, sb.tx_valid_o}, 32'd0);
        chk_log("nom_log");
        abort();
        chk("nom_abort_done", {31'd0, done}, 32'd0);
        chk("nom_abort_sel", {29'd0, sel}, 32'd1);

        // Detect with corruption
        start_run();
        pulse(1, 1, 0);
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        pulse(1, 0, 0);
        repeat (4) pulse(0, 0, 1);
        chk("det_still_pattern", {31'd0, pat}, 32'd1);
        pulse(1, 0, 0);
        repeat (3) pulse(0, 0, 1);
        chk("det_tail_run", {31'd0, pat}, 32'd1);
        pulse(0, 0, 1);
        chk("det_tail_done", {31'd0, pat}, 32'd0);
        abort();

        // Early OOR, partner REQ before own REQ is acked
        msg_log.delete();
        start_run();
        rx(SBINIT_OOR);
        pulse(1, 0, 0);
        pulse(1, 0, 0);
        repeat (4) pulse(0, 0, 1);
        rx(SBINIT_DONE_REQ);
        rx(SBINIT_DONE_RESP);
        wait_done("early_done", 100);
        chk_log("early_log");
        abort();

        // Handshake hold with slow ack
        ack_delay = 7;
        hold_bad = 0;
        msg_log.delete();
        start_run();
        rx(SBINIT_OOR);
        pulse(1, 0, 0);
        pulse(1, 0, 0);
        repeat (4) pulse(0, 0, 1);
        rx(SBINIT_DONE_REQ);
        rx(SBINIT_DONE_RESP);
        wait_done("hold_done", 150);
        chk("hold_stable", hold_bad, 32'd0);
        chk_log("hold_log");
        ack_delay = 1;
        abort();

        // Timeout
        start_run();
        repeat (T - 1) tick();
        chk("to_not_yet", {31'd0, err}, 32'd0);
        tick();
        chk("to_err", {31'd0, err}, 32'd1);
        chk("to_sel", {29'd0, sel}, 32'd1);
        chk("to_valid", {31'd0, sb.tx_valid_o}, 32'd0);
        chk("to_pat", {31'd0, pat}, 32'd0);
        en = 1'b0;
        tick();
        chk("to_clear_err", {31'd0, err}, 32'd0);
        chk("to_clear_sel", {29'd0, sel}, 32'd1);
        en = 1'b1;
        tick();

        // Async reset in OOR
        ack_en = 1'b0;
        start_run();
        pulse(1, 0, 0);
        pulse(1, 0, 0);
        repeat (4) pulse(0, 0, 1);
        tick();
        chk("oor_valid", {31'd0, sb.tx_valid_o}, 32'd1);
        chk("oor_sel", {29'd0, sel}, 32'd3);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_sel", {29'd0, sel}, 32'd1);
        chk("arst_valid", {31'd0, sb.tx_valid_o}, 32'd0);
        chk("arst_msg", {24'd0, sb.tx_msg_o}, 32'd0);
        #1;
        rst = 1'b0;
        ack_en = 1'b1;
        tick();

        // Abort in TAIL, then restart with a fresh timer
        start_run();
        pulse(1, 0, 0);
        pulse(1, 0, 0);
        en = 1'b0;
        tick();
        chk("abort_sel", {29'd0, sel}, 32'd1);
        chk("abort_pat", {31'd0, pat}, 32'd0);
        en = 1'b1;
        start_run();
        chk("restart_sel", {29'd0, sel}, 32'd2);
        repeat (T - 1) tick();
        chk("restart_not_yet", {31'd0, err}, 32'd0);
        tick();
        chk("restart_err", {31'd0, err}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ltsm_sbinit_ctrl.md
Name: ltsm_sbinit_ctrl

Overview:
Sequences the sideband SBINIT phase of the link-training state machine at clk_100MHz. It drives the SB TX pin-mux select, enables the SB clock-pattern generator, and counts detected and transmitted pattern iterations. It exchanges the SBINIT out-of-reset and done request/response messages over the SB message TX/RX handshake. It reports done or error to the LTSM top state machine, which steps to MBINIT or TRAINERROR.

Parameters:
TIMEOUT_CYCLES, 800000, phase timeout in clk_100MHz cycles (8 ms); a sim bench overrides it to 200.
DETECT_ITERS, 2, consecutive error-free RX pattern iterations needed to declare detect.
TAIL_ITERS, 4, extra TX pattern iterations sent after detect.

Ports:
clk_100MHz  in  1  control clock; the block has one clock.
reset  in  1  asynchronous, active-high reset.
enable_i  in  1  block enable; low aborts to IDLE.
start_i  in  1  single-cycle start pulse from LTSM when entering SBINIT.
pattern_iter_done_i  in  1  pulse: pattern generator finished one TX iteration (64 UI clock + 32 UI low).
pattern_detect_i  in  1  pulse: one valid pattern iteration seen on RX.
pattern_err_i  in  1  pulse: RX iteration corrupt.
pattern_tx_en_o  out  1  enables the pattern generator.
sb_tx_sel_o  out  3  SB TX mux select: 0 Z, 1 disabled, 2 SBINIT, 3 COMS.
tx_msg_o  out  8  SB message code to transmit.
tx_valid_o  out  1  message valid.
tx_ack_i  in  1  message accepted by SB TX.
rx_msg_i  in  8  received SB message code.
rx_valid_i  in  1  rx_msg_i valid (1-cycle pulse).
done_o  out  1  SBINIT complete (level).
error_o  out  1  SBINIT timeout (level).

Behaviour:
- Reset values: state IDLE, pattern_tx_en_o=0, sb_tx_sel_o=1, tx_msg_o=0, tx_valid_o=0, done_o=0, error_o=0. All counters, flags and the timer are 0.
- All outputs are registered. Every transition below takes effect on the next clk_100MHz edge.
- States and transitions:
  - IDLE: sel=1. On start_i && enable_i go to PATTERN; clear timer, counters and flags.
  - PATTERN: pattern_tx_en_o=1, sel=2.
    - det_cnt increments on each pattern_detect_i pulse.
    - pattern_err_i clears det_cnt to 0. If both pulse in the same cycle, pattern_err_i wins (cleared to 0).
    - When det_cnt reaches DETECT_ITERS, go to TAIL with tail_cnt=0.
  - TAIL: pattern_tx_en_o=1, sel=2. tail_cnt increments on each pattern_iter_done_i. At TAIL_ITERS go to OOR and drop pattern_tx_en_o.
  - OOR: sel=3.
    - Transmit SBINIT_OOR repeatedly: re-assert tx_valid_o on the cycle after each ack.
    - Exit to DONE_HS when oor_rx_seen=1 and the current message is acked.
  - DONE_HS: sel=3.
    - Send SBINIT_DONE_REQ exactly once.
    - Each partner DONE_REQ received sets resp_pending. Send one SBINIT_DONE_RESP for it.
    - Priority: own REQ is sent before any RESP.
    - Exit to COMPLETE when own REQ is acked, any pending RESP is acked, and resp_rx_seen=1.
  - COMPLETE: done_o=1, sel=3, tx_valid_o=0. Hold until enable_i=0, then go to IDLE with done_o cleared.
  - ERROR: error_o=1, sel=1, pattern_tx_en_o=0, tx_valid_o=0. Hold until enable_i=0, then go to IDLE.
- Received-message flags are latched from PATTERN through DONE_HS:
  - oor_rx_seen is set by SBINIT_OOR received early in PATTERN or TAIL.
  - resp_rx_seen is set by DONE_RESP received in any of these states.
  - Unknown codes are ignored.
- Handshake: tx_valid_o and tx_msg_o stay stable until the cycle tx_ack_i=1. That cycle completes the transfer. tx_ack_i while tx_valid_o=0 is ignored. rx_valid_i and tx_ack_i in the same cycle are both processed.
- Timeout:
  - The timer increments each cycle in PATTERN, TAIL, OOR and DONE_HS.
  - When it reaches TIMEOUT_CYCLES-1, the next state is ERROR. The timeout overrides any simultaneous transition.
  - The timer saturates; it does not wrap.
- Abort: enable_i=0 in any non-IDLE state returns to IDLE next cycle. tx_valid_o and pattern_tx_en_o drop, sel=1, done_o and error_o clear.
- start_i outside IDLE is ignored.
- Counter widths: $clog2(param+1). The timer is $clog2(TIMEOUT_CYCLES) bits.

Decomposition:
- Shared package (sb_codex): SB_mux_sel_t values (0..3), the sbinit_state_t enum, and message codes SBINIT_OOR=8'h01, SBINIT_DONE_REQ=8'h02, SBINIT_DONE_RESP=8'h03.
- Sub-module ltsm_timeout_timer (ports clear, run, expired; parameter CYCLES) is reused later by MBINIT and MBTRAIN.

Test Plan:
1. Nominal path:
   - Stimulus: TIMEOUT_CYCLES=200; start_i; 2 detect pulses; 4 iter_done pulses; partner OOR; partner DONE_REQ then DONE_RESP; ack every valid after 1 cycle.
   - Response: sel 1->2->3; pattern_tx_en_o low after the 4th iter_done; tx_msg sequence 01, 02, 03; done_o=1 before cycle 200.
2. Detect with corruption: detect, err, detect, detect -> TAIL entered only after the 3rd detect; det_cnt resets to 0 on err.
3. Early OOR and REQ/RESP order:
   - Partner OOR arrives during PATTERN -> latched; only one own OOR is sent before DONE_HS.
   - Partner DONE_REQ arrives before own REQ is acked -> own REQ (02) is sent first, then RESP (03).
4. Timeout:
   - Stimulus: never pulse pattern_detect_i.
   - Response: error_o=1 exactly TIMEOUT_CYCLES cycles after start; sel=1; tx_valid_o=0; deassert enable_i -> IDLE with error_o=0.
5. Handshake hold: tx_ack_i delayed 7 cycles -> tx_valid_o and tx_msg_o stay constant for all 7 cycles; no duplicate send.
6. Async reset and abort:
   - reset asserted mid-OOR -> all outputs take reset values immediately, without waiting for a clock edge.
   - enable_i dropped in TAIL -> IDLE next cycle; a following start_i restarts from PATTERN with the timer at 0.
